// File: rtl/jam_pkg.sv
// Shared widths and FSM encoding for the JAM cost-table responder.
// No logic; no latency or backpressure of its own.
package jam_pkg;
    localparam int IDX_W     = 3;
    localparam int COST_W    = 7;
    localparam int N_IDX     = 8;
    localparam int MINCOST_W = 10;
    localparam int MATCH_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/jam_cost_ram.sv
// Cost table storage: one synchronous write port, one synchronous read port.
// Read latency 1 cycle, read every cycle; no backpressure (always accepts).
module jam_cost_ram
    import jam_pkg::*;
#(
    parameter int DATA_W = COST_W,
    parameter int ADDR_W = 2 * IDX_W
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/jam_cost_server.sv
// Holds the worker/job cost table, answers (W,J) lookups, and scores the engine result.
// Lookup latency 1 cycle; load beats back-pressured (ld_ready=0) while serving or done.
module jam_cost_server #(
    parameter int N_IDX   = 8,
    parameter int COST_W  = 7,
    parameter int TIMEOUT = 65535
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [COST_W-1:0]             ld_data,
    input  logic                          go,
    input  logic                          clr,
    input  logic [$clog2(N_IDX)-1:0]      W,
    input  logic [$clog2(N_IDX)-1:0]      J,
    output logic [COST_W-1:0]             Cost,
    input  logic                          Valid,
    input  logic [jam_pkg::MINCOST_W-1:0] MinCost,
    input  logic [jam_pkg::MATCH_W-1:0]   MatchCount,
    input  logic [jam_pkg::MINCOST_W-1:0] exp_min_cost,
    input  logic [jam_pkg::MATCH_W-1:0]   exp_match_count,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [jam_pkg::MINCOST_W-1:0] res_min_cost,
    output logic [jam_pkg::MATCH_W-1:0]   res_match_count,
    output logic [15:0]                   lookup_cnt
);
    import jam_pkg::*;

    localparam int          DEPTH   = N_IDX * N_IDX;
    localparam int          AW      = 2 * $clog2(N_IDX);
    localparam logic [31:0] TMO_LIM = TIMEOUT;

    state_t            state_q, state_d;
    logic   [AW-1:0]   ld_cnt;
    logic              loaded;
    logic              ld_acc;
    logic              last_beat;
    logic   [15:0]     cnt_inc;
    logic              expire;
    logic [COST_W-1:0] rd_q;

    assign ld_acc    = ld_valid & ld_ready;
    assign last_beat = ld_acc && (ld_cnt == AW'(DEPTH - 1));
    assign cnt_inc   = (lookup_cnt == 16'hFFFF) ? lookup_cnt : lookup_cnt + 16'd1;
    assign expire    = ({16'd0, cnt_inc} >= TMO_LIM);

    jam_cost_ram #(
        .DATA_W (COST_W),
        .ADDR_W (AW)
    ) u_ram (
        .CLK   (CLK),
        .we    (ld_acc),
        .waddr (ld_cnt),
        .wdata (ld_data),
        .raddr ({W, J}),
        .rdata (rd_q)
    );

    // The RAM reads every cycle; only lookups made while serving become visible.
    assign Cost = (state_q == SERVE) ? rd_q : '0;

    always_comb begin
        state_d  = state_q;
        ld_ready = 1'b0;
        case (state_q)
            IDLE: begin
                ld_ready = 1'b1;
                if (ld_acc)            state_d = LOAD;
                else if (go && loaded) state_d = SERVE;
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (last_beat) state_d = IDLE;
            end
            SERVE:   if (Valid || expire) state_d = DONE;
            DONE:    if (clr)             state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            loaded          <= 1'b0;
            ld_cnt          <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            res_min_cost    <= '0;
            res_match_count <= '0;
            lookup_cnt      <= '0;
        end else begin
            if (ld_acc) begin
                ld_cnt <= last_beat ? '0 : ld_cnt + AW'(1);
                if (state_q == IDLE) loaded <= 1'b0;
                if (last_beat)       loaded <= 1'b1;
            end
            case (state_q)
                IDLE: if (!ld_acc && go && loaded) lookup_cnt <= '0;
                SERVE: begin
                    lookup_cnt <= cnt_inc;
                    // A result arriving on the expiry cycle still counts.
                    if (Valid) begin
                        res_min_cost    <= MinCost;
                        res_match_count <= MatchCount;
                        pass            <= (MinCost == exp_min_cost) &&
                                           (MatchCount == exp_match_count);
                        done            <= 1'b1;
                    end else if (expire) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: if (clr) begin
                    done            <= 1'b0;
                    pass            <= 1'b0;
                    timeout         <= 1'b0;
                    res_min_cost    <= '0;
                    res_match_count <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jam_cost_server.sv
// Randomized bench for jam_cost_server with a behavioural reference model checked every cycle.
module tb_jam_cost_server;
    localparam int TMO = 20;
    localparam int P_IDLE = 0, P_LOAD = 1, P_SERVE = 2, P_DONE = 3;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [6:0] ld_data = '0;
    logic       go = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] W = '0;
    logic [2:0] J = '0;
    logic [6:0] Cost;
    logic       Valid = 1'b0;
    logic [9:0] MinCost = '0;
    logic [3:0] MatchCount = '0;
    logic [9:0] exp_min_cost = '0;
    logic [3:0] exp_match_count = '0;
    logic       done, pass, timeout;
    logic [9:0] res_min_cost;
    logic [3:0] res_match_count;
    logic [15:0] lookup_cnt;

    jam_cost_server #(.N_IDX(8), .COST_W(7), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .go(go), .clr(clr), .W(W), .J(J), .Cost(Cost),
        .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
        .exp_min_cost(exp_min_cost), .exp_match_count(exp_match_count),
        .done(done), .pass(pass), .timeout(timeout),
        .res_min_cost(res_min_cost), .res_match_count(res_match_count),
        .lookup_cnt(lookup_cnt)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: table image only becomes usable once all 64 beats have arrived.
    int m_ph = P_IDLE;
    int m_tbl [64];
    int m_beats [$];
    bit m_loaded = 1'b0;
    int m_cost = 0, m_done = 0, m_pass = 0, m_tmo = 0, m_rmin = 0, m_rmc = 0, m_lcnt = 0;

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_ph = P_IDLE; m_loaded = 1'b0; m_beats.delete();
            m_done = 0; m_pass = 0; m_tmo = 0; m_rmin = 0; m_rmc = 0; m_lcnt = 0;
        end else begin
            case (m_ph)
                P_IDLE: begin
                    if (ld_valid) begin
                        m_beats.delete();
                        m_beats.push_back(int'(ld_data));
                        m_loaded = 1'b0;
                        m_ph = P_LOAD;
                    end else if (go && m_loaded) begin
                        m_lcnt = 0;
                        m_ph = P_SERVE;
                    end
                end
                P_LOAD: begin
                    if (ld_valid) begin
                        m_beats.push_back(int'(ld_data));
                        if (m_beats.size() == 64) begin
                            foreach (m_tbl[i]) m_tbl[i] = m_beats[i];
                            m_loaded = 1'b1;
                            m_ph = P_IDLE;
                        end
                    end
                end
                P_SERVE: begin
                    m_lcnt = (m_lcnt < 65535) ? m_lcnt + 1 : 65535;
                    if (Valid) begin
                        m_rmin = int'(MinCost);
                        m_rmc = int'(MatchCount);
                        m_pass = (MinCost == exp_min_cost && MatchCount == exp_match_count) ? 1 : 0;
                        m_done = 1;
                        m_ph = P_DONE;
                    end else if (m_lcnt >= TMO) begin
                        m_tmo = 1; m_pass = 0; m_done = 1;
                        m_ph = P_DONE;
                    end
                end
                default: begin
                    if (clr) begin
                        m_done = 0; m_pass = 0; m_tmo = 0; m_rmin = 0; m_rmc = 0;
                        m_ph = P_IDLE;
                    end
                end
            endcase
        end
        m_cost = (RST_N && m_ph == P_SERVE) ? m_tbl[int'(W) * 8 + int'(J)] : 0;
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("ld_ready", ld_ready, (m_ph == P_IDLE || m_ph == P_LOAD) ? 1 : 0);
            check("cost", Cost, m_cost);
            check("done", done, m_done);
            check("pass", pass, m_pass);
            check("timeout", timeout, m_tmo);
            check("res_min_cost", res_min_cost, m_rmin);
            check("res_match_count", res_match_count, m_rmc);
            check("lookup_cnt", lookup_cnt, m_lcnt);
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    // mode 0: data k+1, no gaps; mode 1: valid every other cycle; mode 2: random data/gaps/go noise
    task automatic load_table(input int mode, input int n_beats);
        int k = 0;
        int guard = 0;
        while (k < n_beats && guard < 2000) begin
            ld_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(guard % 2 == 0) : 1'($urandom_range(0, 1));
            ld_data  = (mode == 0) ? 7'(k + 1) : 7'($urandom);
            go       = (mode == 2) ? 1'($urandom_range(0, 7) == 0) : 1'b0;
            if (ld_valid && ld_ready) k++;
            tick();
            guard++;
        end
        ld_valid = 1'b0;
        go = 1'b0;
        if (guard >= 2000) check("load_budget", 32'(k), 32'(n_beats));
    endtask

    task automatic serve_run(input int delay, input logic [9:0] mc, input logic [3:0] mm,
                             input logic [9:0] emc, input logic [3:0] emm);
        go = 1'b1; W = 3'($urandom); J = 3'($urandom);
        tick();
        go = 1'b0;
        repeat (delay) begin
            W = 3'($urandom); J = 3'($urandom);
            tick();
        end
        MinCost = mc; MatchCount = mm; exp_min_cost = emc; exp_match_count = emm;
        Valid = 1'b1;
        tick();
        Valid = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time budget exceeded");
        $fatal(1);
    end

    initial begin
        logic [9:0] mc;
        logic [3:0] mm;
        RST_N = 1'b0;
        repeat (3) tick();
        RST_N = 1'b1;
        chk_en = 1'b1;
        check("rst_cost", Cost, 0);
        check("rst_done", done, 0);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_lookup_cnt", lookup_cnt, 0);

        // Result valid while idle is ignored; go without a table is ignored.
        Valid = 1'b1; MinCost = 10'd5; go = 1'b1;
        repeat (2) tick();
        Valid = 1'b0; go = 1'b0;
        check("idle_valid_done", done, 0);
        check("go_unloaded_ready", ld_ready, 1);

        // Valid during load is ignored as well.
        Valid = 1'b1;
        load_table(0, 5);
        Valid = 1'b0;
        load_table(0, 0);
        RST_N = 1'b0; tick(); RST_N = 1'b1;
        load_table(0, 64);
        check("load_done_ready", ld_ready, 1);

        go = 1'b1; W = 3'd3; J = 3'd5; tick(); go = 1'b0;
        check("cost_w3j5", Cost, 30);
        W = 3'd7; J = 3'd7; tick();
        check("cost_w7j7", Cost, 64);
        W = 3'd0; J = 3'd0; tick();
        check("cost_w0j0", Cost, 1);
        MinCost = 10'd123; MatchCount = 4'd2; exp_min_cost = 10'd123; exp_match_count = 4'd2;
        Valid = 1'b1; tick(); Valid = 1'b0;
        check("match_done", done, 1);
        check("match_pass", pass, 1);
        check("match_res_min", res_min_cost, 123);
        check("done_cost_zero", Cost, 0);
        clr = 1'b1; tick(); clr = 1'b0; tick();

        go = 1'b1; tick(); go = 1'b0;
        MatchCount = 4'd3; Valid = 1'b1; tick(); Valid = 1'b0;
        check("mismatch_done", done, 1);
        check("mismatch_pass", pass, 0);
        clr = 1'b1; tick(); clr = 1'b0; tick();

        // Timeout: done exactly on the 20th serve cycle.
        go = 1'b1; tick(); go = 1'b0;
        repeat (19) tick();
        check("tmo_not_yet", done, 0);
        tick();
        check("tmo_done", done, 1);
        check("tmo_flag", timeout, 1);
        check("tmo_pass", pass, 0);
        check("tmo_cnt", lookup_cnt, 20);
        clr = 1'b1; tick(); clr = 1'b0; tick();
        check("clr_ready", ld_ready, 1);
        go = 1'b1; W = 3'd3; J = 3'd5; tick(); go = 1'b0;
        check("rerun_cost", Cost, 30);
        clr = 1'b1; repeat (25) tick(); clr = 1'b0; tick();

        // Valid coinciding with expiry wins.
        serve_run(19, 10'd77, 4'd1, 10'd77, 4'd1);

        // Reset mid-load forces a full reload.
        load_table(2, 30);
        RST_N = 1'b0; tick(); RST_N = 1'b1;
        go = 1'b1; tick(); go = 1'b0;
        check("midload_rst_idle", ld_ready, 1);
        load_table(1, 64);
        check("toggle_load_ready", ld_ready, 1);
        go = 1'b1; tick(); go = 1'b0;
        check("toggle_go_serve", ld_ready, 0);
        repeat (25) tick();
        clr = 1'b1; tick(); clr = 1'b0; tick();

        for (int it = 0; it < 8; it++) begin
            load_table(2, 64);
            tick();
            for (int s = 0; s < 3; s++) begin
                mc = 10'($urandom); mm = 4'($urandom);
                serve_run($urandom_range(0, 24), mc, mm,
                          ($urandom_range(0, 1) == 1) ? mc : 10'($urandom),
                          ($urandom_range(0, 1) == 1) ? mm : 4'($urandom));
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
